// File: rtl/majority_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | majority_pkg : address layout, state encoding and address helper for   |
// |                the segment read-back / voting stage.                   |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
package majority_pkg;

  localparam int WORD_LSB   = 0;
  localparam int COPY_LSB   = 6;
  localparam int SEG_LSB    = 8;
  localparam int ADDR_W     = 25;
  localparam int NUM_COPIES = 3;
  localparam int DATA_W     = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VOTE  = 2'd3
  } vote_state_t;

  function automatic logic [ADDR_W-1:0] make_addr(input logic [15:0] seg,
                                                  input logic [1:0]  copy,
                                                  input logic [5:0]  word);
    logic [ADDR_W-1:0] a;
    a                    = '0;
    a[SEG_LSB  +: 16]    = seg;
    a[COPY_LSB +: 2]     = copy;
    a[WORD_LSB +: 6]     = word;
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/majority3_256.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | majority3_256 : bitwise 2-of-3 vote over three 256-bit copies, plus a  |
// |                 flag raised when any bit position disagrees.           |
// | Revision      : 1.0                                                    |
// +------------------------------------------------------------------------+
module majority3_256
  import majority_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] vote,
  output logic              mismatch
);

  always_comb begin
    vote     = (a & b) | (a & c) | (b & c);
    mismatch = |((a ^ b) | (a ^ c));
  end

endmodule
`default_nettype wire

// File: rtl/majority_vote_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | majority_vote_reader : reads the three stored copies of every word of  |
// |                        a segment through the MIG read port and emits   |
// |                        one tagged 2-of-3 voted word per word index.    |
// | Revision             : 1.0                                             |
// +------------------------------------------------------------------------+
module majority_vote_reader
  import majority_pkg::*;
#(
  parameter int NUM_WORDS = 48
)
(
  input  logic              clk,
  input  logic              RST,
  input  logic              seg_valid,
  input  logic [15:0]       seg_num,
  output logic              seg_ready,
  input  logic              rd_busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic [DATA_W-1:0] vote_data,
  output logic              vote_valid,
  output logic [5:0]        vote_word,
  output logic [15:0]       vote_segnum,
  output logic              vote_last,
  output logic              vote_mismatch
);

  localparam logic [1:0] LAST_COPY = 2'(NUM_COPIES - 1);
  localparam logic [5:0] LAST_WORD = 6'(NUM_WORDS - 1);

  vote_state_t       state_q, state_d;
  logic [15:0]       seg_q, seg_d;
  logic [5:0]        word_q, word_d;
  logic [1:0]        copy_q, copy_d;
  logic [1:0]        ret_q, ret_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] vote_data_q, vote_data_d;
  logic              vote_valid_q, vote_valid_d;
  logic [5:0]        vote_word_q, vote_word_d;
  logic [15:0]       vote_segnum_q, vote_segnum_d;
  logic              vote_last_q, vote_last_d;
  logic              vote_mismatch_q, vote_mismatch_d;

  logic [DATA_W-1:0] maj_vote;
  logic              maj_mismatch;
  logic              take;

  // The third copy is voted straight off the read bus so the result is
  // registered on the same edge that samples it.
  majority3_256 u_majority3_256 (
    .a        (a_q),
    .b        (b_q),
    .c        (rd_data),
    .vote     (maj_vote),
    .mismatch (maj_mismatch)
  );

  assign take = rd_en_q & ~rd_busy;

  always_comb begin
    state_d         = state_q;
    seg_d           = seg_q;
    word_d          = word_q;
    copy_d          = copy_q;
    ret_d           = ret_q;
    a_d             = a_q;
    b_d             = b_q;
    rd_en_d         = rd_en_q;
    rd_addr_d       = rd_addr_q;
    vote_data_d     = vote_data_q;
    vote_valid_d    = 1'b0;
    vote_word_d     = vote_word_q;
    vote_segnum_d   = vote_segnum_q;
    vote_last_d     = 1'b0;
    vote_mismatch_d = vote_mismatch_q;

    // Returns may overlap the tail of ISSUE; only IDLE drops them.
    if (state_q != ST_IDLE && rd_data_valid) begin
      case (ret_q)
        2'd0:    a_d = rd_data;
        2'd1:    b_d = rd_data;
        default: ;
      endcase
      ret_d = ret_q + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (seg_valid) begin
          seg_d     = seg_num;
          word_d    = 6'd0;
          copy_d    = 2'd0;
          ret_d     = 2'd0;
          rd_en_d   = 1'b1;
          rd_addr_d = make_addr(seg_num, 2'd0, 6'd0);
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (take) begin
          copy_d = copy_q + 2'd1;
          if (copy_q == LAST_COPY) begin
            rd_en_d = 1'b0;
            state_d = ST_WAIT;
          end else begin
            rd_addr_d = make_addr(seg_q, copy_q + 2'd1, word_q);
          end
        end
      end

      ST_WAIT: begin
        if (rd_data_valid && ret_q == 2'd2) begin
          vote_data_d     = maj_vote;
          vote_mismatch_d = maj_mismatch;
          vote_valid_d    = 1'b1;
          vote_word_d     = word_q;
          vote_segnum_d   = seg_q;
          vote_last_d     = (word_q == LAST_WORD);
          state_d         = ST_VOTE;
        end
      end

      ST_VOTE: begin
        if (word_q == LAST_WORD) begin
          state_d = ST_IDLE;
        end else begin
          word_d    = word_q + 6'd1;
          copy_d    = 2'd0;
          ret_d     = 2'd0;
          rd_en_d   = 1'b1;
          rd_addr_d = make_addr(seg_q, 2'd0, word_q + 6'd1);
          state_d   = ST_ISSUE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q         <= ST_IDLE;
      seg_q           <= '0;
      word_q          <= '0;
      copy_q          <= '0;
      ret_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= '0;
      vote_data_q     <= '0;
      vote_valid_q    <= 1'b0;
      vote_word_q     <= '0;
      vote_segnum_q   <= '0;
      vote_last_q     <= 1'b0;
      vote_mismatch_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      seg_q           <= seg_d;
      word_q          <= word_d;
      copy_q          <= copy_d;
      ret_q           <= ret_d;
      a_q             <= a_d;
      b_q             <= b_d;
      rd_en_q         <= rd_en_d;
      rd_addr_q       <= rd_addr_d;
      vote_data_q     <= vote_data_d;
      vote_valid_q    <= vote_valid_d;
      vote_word_q     <= vote_word_d;
      vote_segnum_q   <= vote_segnum_d;
      vote_last_q     <= vote_last_d;
      vote_mismatch_q <= vote_mismatch_d;
    end
  end

  assign seg_ready     = (state_q == ST_IDLE);
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign vote_data     = vote_data_q;
  assign vote_valid    = vote_valid_q;
  assign vote_word     = vote_word_q;
  assign vote_segnum   = vote_segnum_q;
  assign vote_last     = vote_last_q;
  assign vote_mismatch = vote_mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_majority_vote_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_majority_vote_reader : bench for majority_vote_reader with a MIG    |
// |                           read-port model and a behavioural reference. |
// | Revision                : 1.0                                          |
// +------------------------------------------------------------------------+
module tb_majority_vote_reader;

  localparam int NW = 2;

  logic         clk = 1'b0;
  logic         RST = 1'b0;
  logic         seg_valid = 1'b0;
  logic [15:0]  seg_num = '0;
  logic         seg_ready;
  logic         rd_busy = 1'b0;
  logic         rd_en;
  logic [24:0]  rd_addr;
  logic [255:0] rd_data = '0;
  logic         rd_data_valid = 1'b0;
  logic [255:0] vote_data;
  logic         vote_valid;
  logic [5:0]   vote_word;
  logic [15:0]  vote_segnum;
  logic         vote_last;
  logic         vote_mismatch;

  always #5 clk = ~clk;

  majority_vote_reader #(.NUM_WORDS(NW)) dut (
    .clk           (clk),
    .RST           (RST),
    .seg_valid     (seg_valid),
    .seg_num       (seg_num),
    .seg_ready     (seg_ready),
    .rd_busy       (rd_busy),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .vote_data     (vote_data),
    .vote_valid    (vote_valid),
    .vote_word     (vote_word),
    .vote_segnum   (vote_segnum),
    .vote_last     (vote_last),
    .vote_mismatch (vote_mismatch)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // DDR contents and MIG read-port model
  logic [255:0] mem [int];
  int  pend_addr[$];
  int  pend_due[$];
  int  taken_log[$];
  int  cyc = 0;
  int  lat = 0;
  int  resp_prob = 100;
  int  busy_prob = 0;
  int  busy_cnt = 0;
  bit  pause = 1'b0;
  int  delivered = 0;

  function automatic logic [255:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  function automatic int addr_of(input int seg, input int copy, input int word);
    return seg * 256 + copy * 64 + word;
  endfunction

  task automatic set_word(input int seg, input int w, input logic [255:0] c0,
                          input logic [255:0] c1, input logic [255:0] c2);
    mem[addr_of(seg, 0, w)] = c0;
    mem[addr_of(seg, 1, w)] = c1;
    mem[addr_of(seg, 2, w)] = c2;
  endtask

  task automatic step();
    if (rd_en && !rd_busy) begin
      pend_addr.push_back(int'(rd_addr));
      pend_due.push_back(cyc + 1 + lat);
      taken_log.push_back(int'(rd_addr));
    end
    @(posedge clk);
    #1;
    cyc++;
    rd_data_valid = 1'b0;
    rd_data       = rand256();
    if (!pause && pend_addr.size() > 0 && cyc >= pend_due[0] &&
        $urandom_range(99) < resp_prob) begin
      rd_data_valid = 1'b1;
      rd_data       = mem_rd(pend_addr.pop_front());
      pend_due.delete(0);
      delivered++;
    end
    if (busy_cnt > 0) begin
      rd_busy = 1'b1;
      busy_cnt--;
    end else begin
      rd_busy = ($urandom_range(99) < busy_prob);
    end
  endtask

  // Reference model: expected reads and votes derived from memory contents
  typedef struct {
    logic [255:0] d;
    int           w;
    int           s;
    bit           last;
    bit           mm;
  } vote_t;

  vote_t exp_v[$];
  vote_t vote_log[$];
  int    exp_addr[$];
  bit    active = 1'b0;
  int    rem = 0;
  int    ret = 0;
  bit    exp_vv = 1'b0;
  bit    prev_hold = 1'b0;
  logic [24:0] prev_addr = '0;
  int    votes_seen = 0;

  function automatic void build_model(input int seg);
    for (int w = 0; w < NW; w++) begin
      vote_t v;
      logic [255:0] cp [3];
      for (int c = 0; c < 3; c++) begin
        cp[c] = mem_rd(addr_of(seg, c, w));
        exp_addr.push_back(addr_of(seg, c, w));
      end
      v.d  = '0;
      v.mm = 1'b0;
      for (int i = 0; i < 256; i++) begin
        int n;
        n = int'(cp[0][i]) + int'(cp[1][i]) + int'(cp[2][i]);
        v.d[i] = (n >= 2);
        if (n == 1 || n == 2) v.mm = 1'b1;
      end
      v.w    = w;
      v.s    = seg;
      v.last = (w == NW - 1);
      exp_v.push_back(v);
    end
  endfunction

  always @(negedge clk) begin
    if (!RST) begin
      chk("reset_rd_en", rd_en, 0);
      chk("reset_rd_addr", rd_addr, 0);
      chk("reset_seg_ready", seg_ready, 1);
      chk("reset_vote_valid", vote_valid, 0);
      chk("reset_vote_data", vote_data, 0);
      chk("reset_vote_word", vote_word, 0);
      chk("reset_vote_segnum", vote_segnum, 0);
      chk("reset_vote_last", vote_last, 0);
      chk("reset_vote_mismatch", vote_mismatch, 0);
      active    = 1'b0;
      rem       = 0;
      ret       = 0;
      exp_vv    = 1'b0;
      prev_hold = 1'b0;
      exp_v.delete();
      exp_addr.delete();
    end else begin
      bit was_active;
      bit next_vv;
      was_active = active;
      next_vv    = 1'b0;
      chk("seg_ready", seg_ready, !active);
      chk("rd_en", rd_en, rem > 0);
      chk("vote_valid", vote_valid, exp_vv);
      if (prev_hold) chk("busy_hold_addr", rd_addr, prev_addr);
      if (rd_en && !rd_busy) begin
        if (exp_addr.size() == 0) fail("unexpected_read");
        else chk("rd_addr", rd_addr, exp_addr.pop_front());
        if (rem > 0) rem--;
      end
      if (vote_valid) begin
        vote_t got;
        got.d = vote_data; got.w = vote_word; got.s = vote_segnum;
        got.last = vote_last; got.mm = vote_mismatch;
        vote_log.push_back(got);
        votes_seen++;
        if (exp_v.size() == 0) begin
          fail("unexpected_vote");
        end else begin
          vote_t e;
          e = exp_v.pop_front();
          chk("vote_data", vote_data, e.d);
          chk("vote_word", vote_word, e.w);
          chk("vote_segnum", vote_segnum, e.s);
          chk("vote_last", vote_last, e.last);
          chk("vote_mismatch", vote_mismatch, e.mm);
          if (e.last) active = 1'b0;
          else rem = 3;
        end
      end
      if (was_active && rd_data_valid) begin
        ret++;
        if (ret == 3) begin
          ret     = 0;
          next_vv = 1'b1;
        end
      end
      if (!was_active && seg_valid) begin
        active = 1'b1;
        rem    = 3;
        ret    = 0;
        build_model(int'(seg_num));
      end
      prev_hold = rd_en && rd_busy;
      prev_addr = rd_addr;
      exp_vv    = next_vv;
    end
  end

  task automatic request(input int seg);
    bit acc;
    bit ok;
    ok        = 1'b0;
    seg_valid = 1'b1;
    seg_num   = 16'(seg);
    for (int i = 0; i < 200; i++) begin
      acc = seg_ready;
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    seg_valid = 1'b0;
    if (!ok) fail("accept_timeout");
  endtask

  task automatic run_seg(input int seg, input bit busy_after_first);
    int  start_votes;
    int  start_taken;
    bit  done;
    bit  hold_done;
    start_votes = votes_seen;
    start_taken = taken_log.size();
    hold_done   = 1'b0;
    request(seg);
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (busy_after_first && !hold_done && taken_log.size() - start_taken == 1) begin
        rd_busy   = 1'b1;
        busy_cnt  = 4;
        hold_done = 1'b1;
      end
      if (votes_seen - start_votes >= NW && seg_ready && pend_addr.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) fail("segment_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] a5;
    logic [255:0] ones;
    logic [255:0] pat;
    int           exp_a [6];
    int           d0;
    int           t0;

    a5   = {32{8'hA5}};
    ones = '1;

    RST = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    step();

    // identical copies, seg 0x0012
    set_word(16'h0012, 0, a5, a5, a5);
    set_word(16'h0012, 1, a5, a5, a5);
    taken_log.delete();
    vote_log.delete();
    run_seg(16'h0012, 1'b0);
    exp_a = '{32'h1200, 32'h1240, 32'h1280, 32'h1201, 32'h1241, 32'h1281};
    chk("t1_read_count", taken_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < taken_log.size()) chk("t1_read_addr", taken_log[i], exp_a[i]);
    chk("t1_vote_count", vote_log.size(), 2);
    if (vote_log.size() == 2) begin
      chk("t1_vote0_data", vote_log[0].d, a5);
      chk("t1_vote1_data", vote_log[1].d, a5);
      chk("t1_vote0_mm", vote_log[0].mm, 0);
      chk("t1_vote0_last", vote_log[0].last, 0);
      chk("t1_vote1_last", vote_log[1].last, 1);
    end

    // single dissenting copy of all ones
    set_word(16'h0345, 0, '0, ones, '0);
    set_word(16'h0345, 1, rand256(), rand256(), rand256());
    vote_log.delete();
    run_seg(16'h0345, 1'b0);
    if (vote_log.size() > 0) begin
      chk("t2_vote_data", vote_log[0].d, 0);
      chk("t2_vote_mm", vote_log[0].mm, 1);
    end else fail("t2_no_vote");

    // three mutually differing copies
    set_word(16'h0777, 0, {32{8'hF0}}, {32{8'hCC}}, {32{8'hAA}});
    pat = rand256();
    set_word(16'h0777, 1, pat, pat ^ rand256(), pat ^ rand256());
    vote_log.delete();
    run_seg(16'h0777, 1'b0);
    if (vote_log.size() > 0) begin
      chk("t3_vote_data", vote_log[0].d, {32{8'hE8}});
      chk("t3_vote_mm", vote_log[0].mm, 1);
    end else fail("t3_no_vote");

    // MIG busy for 5 cycles after the first read of the segment
    set_word(16'h1234, 0, rand256(), rand256(), rand256());
    set_word(16'h1234, 1, rand256(), rand256(), rand256());
    taken_log.delete();
    run_seg(16'h1234, 1'b1);
    chk("t4_read_count", taken_log.size(), 6);

    // zero-latency returns overlap the issue phase
    lat       = 0;
    resp_prob = 100;
    set_word(16'h00AB, 0, rand256(), rand256(), rand256());
    set_word(16'h00AB, 1, rand256(), rand256(), rand256());
    vote_log.delete();
    run_seg(16'h00AB, 1'b0);
    chk("t5_vote_count", vote_log.size(), 2);

    // reset during WAIT with one copy back; two stale returns follow in IDLE
    lat = 3;
    set_word(16'h0BAD, 0, rand256(), rand256(), rand256());
    d0 = delivered;
    vote_log.delete();
    request(16'h0BAD);
    for (int i = 0; i < 100; i++) begin
      if (delivered - d0 >= 1) break;
      step();
    end
    pause = 1'b1;
    step();
    RST = 1'b0;
    repeat (3) step();
    RST   = 1'b1;
    pause = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pend_addr.size() == 0) break;
      step();
    end
    repeat (3) step();
    chk("t6_stale_returns", delivered - d0, 3);
    chk("t6_no_vote", vote_log.size(), 0);
    lat = 1;
    set_word(16'h0C01, 0, rand256(), rand256(), rand256());
    set_word(16'h0C01, 1, rand256(), rand256(), rand256());
    t0 = taken_log.size();
    run_seg(16'h0C01, 1'b0);
    if (taken_log.size() > t0) chk("t6_first_addr", taken_log[t0], 32'h0C0100);
    else fail("t6_no_read");

    // randomized traffic: busy, latency and return gaps all vary
    busy_prob = 30;
    resp_prob = 60;
    for (int s = 0; s < 8; s++) begin
      int seg;
      seg = int'($urandom_range(16'hFFFF));
      lat = int'($urandom_range(4));
      for (int w = 0; w < NW; w++) begin
        pat = rand256();
        case ($urandom_range(3))
          0: set_word(seg, w, pat, pat, pat);
          1: set_word(seg, w, pat, pat ^ rand256(), pat);
          2: set_word(seg, w, rand256(), rand256(), rand256());
          default: set_word(seg, w, pat ^ (256'(1) << $urandom_range(255)), pat, pat);
        endcase
      end
      run_seg(seg, 1'b0);
    end

    repeat (4) step();
    chk("final_votes_drained", exp_v.size(), 0);
    chk("final_reads_drained", exp_addr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
